// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory access controller.
// The wait counter is sized so that WAIT_STATES can range from 0 to 15.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the control unit (master) and the memory controller (slave).
interface data_mem_ctrl_if import mem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              mdr_read;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req_rd, req_wr, addr, wr_data,
        input  rd_data, mdr_read, busy, done, err
    );

    modport slave (
        input  req_rd, req_wr, addr, wr_data,
        output rd_data, mdr_read, busy, done, err
    );

endinterface

// File: rtl/data_ram.sv
// Single-port data RAM: synchronous write, registered read, array deliberately not reset.
module data_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: accepts a MAR-addressed read or write, inserts
// WAIT_STATES idle cycles, accesses the RAM, then strobes the MDR on reads.
module data_mem_ctrl import mem_pkg::*; #(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              op_wr_q;
    logic              err_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;
    logic              conflict;
    logic              ram_we;
    logic              ram_re;
    logic              busy;
    logic              done;
    logic              mdr_read;

    assign accept   = (state_q == IDLE) && (bus.req_rd ^ bus.req_wr);
    assign conflict = (state_q == IDLE) && bus.req_rd && bus.req_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt_q <= CNT_W'(1)) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = CNT_W'(WAIT_STATES);
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Request fields are captured only on acceptance so later bus changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= conflict;
            if (accept) begin
                addr_q    <= bus.addr;
                wr_data_q <= bus.wr_data;
                op_wr_q   <= bus.req_wr;
            end
            if (mdr_read) begin
                rd_data_q <= ram_rdata;
            end
        end
    end

    // The write strobe is gated by rst_n so a reset on the ACCESS edge leaves the RAM untouched.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == RESP);
        mdr_read = (state_q == RESP) && !op_wr_q;
        ram_we   = (state_q == ACCESS) && op_wr_q && rst_n;
        ram_re   = (state_q == ACCESS) && !op_wr_q;
    end

    data_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q),
        .wdata_i (wr_data_q),
        .rdata_o (ram_rdata)
    );

    // The fresh RAM byte is forwarded during RESP so rd_data is valid alongside the mdr_read strobe.
    assign bus.rd_data  = mdr_read ? ram_rdata : rd_data_q;
    assign bus.mdr_read = mdr_read;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with two wait states, one with none.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ifA ();
    data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) ifB ();

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    data_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit b, input logic rd, input logic wr,
                                 input logic [7:0] a, input logic [7:0] d);
        if (b) begin
            ifB.req_rd = rd; ifB.req_wr = wr; ifB.addr = a; ifB.wr_data = d;
        end else begin
            ifA.req_rd = rd; ifA.req_wr = wr; ifA.addr = a; ifA.wr_data = d;
        end
    endtask

    // Status word: {busy, done, mdr_read, err, rd_data}
    function automatic logic [11:0] status(input bit b);
        if (b) return {ifB.busy, ifB.done, ifB.mdr_read, ifB.err, ifB.rd_data};
        return {ifA.busy, ifA.done, ifA.mdr_read, ifA.err, ifA.rd_data};
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    // One full transaction, checked every cycle; meddle drives a stray request and new addr/data while busy.
    task automatic runTxn(input bit b, input bit isWr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rdBefore, input logic [7:0] rdAfter, input int ws,
                          input bit meddle, input string tag);
        logic [11:0] exp;
        applyStimulus(b, !isWr, isWr, a, d);
        for (int k = 1; k <= ws + 4; k++) begin
            cyc();
            exp = {(k <= ws + 2), (k == ws + 2), (!isWr && (k == ws + 2)), 1'b0,
                   ((k >= ws + 2) ? rdAfter : rdBefore)};
            checkOutput($sformatf("%s k=%0d", tag, k), status(b), exp);
            if (k == 1) applyStimulus(b, meddle, 1'b0, meddle ? 8'h20 : a, meddle ? 8'hFF : d);
            if (meddle && k == 2) applyStimulus(b, 1'b1, 1'b0, 8'h30, 8'hEE);
            if (k == ws + 1) applyStimulus(b, 1'b0, 1'b0, a, d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 8'h00);
        cyc();
        cyc();
        checkOutput("resetA", status(0), 12'h000);
        checkOutput("resetB", status(1), 12'h000);
        rst_n = 1'b1;
        cyc();

        runTxn(0, 1, 8'h10, 8'hA5, 8'h00, 8'h00, 2, 0, "wrA5");
        runTxn(0, 0, 8'h10, 8'h00, 8'h00, 8'hA5, 2, 0, "rdA5");

        applyStimulus(0, 1, 1, 8'h10, 8'h00);
        cyc();
        checkOutput("errPulse", status(0), 12'h1A5);
        applyStimulus(0, 0, 0, 8'h10, 8'h00);
        cyc();
        checkOutput("errClear", status(0), 12'h0A5);
        runTxn(0, 0, 8'h10, 8'h00, 8'hA5, 8'hA5, 2, 0, "rdAfterErr");

        runTxn(0, 1, 8'h20, 8'h66, 8'hA5, 8'hA5, 2, 0, "wr20");
        runTxn(0, 1, 8'h30, 8'h5A, 8'hA5, 8'hA5, 2, 0, "wr30");
        runTxn(0, 0, 8'h10, 8'h00, 8'hA5, 8'hA5, 2, 1, "rdLatched");
        runTxn(0, 1, 8'h50, 8'h81, 8'hA5, 8'hA5, 2, 1, "wrLatched");
        runTxn(0, 0, 8'h50, 8'h00, 8'hA5, 8'h81, 2, 0, "rd50");
        runTxn(0, 0, 8'h30, 8'h00, 8'h81, 8'h5A, 2, 0, "rd30");
        runTxn(0, 0, 8'h20, 8'h00, 8'h5A, 8'h66, 2, 0, "rd20");

        runTxn(0, 1, 8'h40, 8'h00, 8'h66, 8'h66, 2, 0, "wr40Zero");
        applyStimulus(0, 0, 1, 8'h40, 8'h3C);
        cyc();
        applyStimulus(0, 0, 0, 8'h40, 8'h3C);
        checkOutput("wr3CAccepted", status(0), 12'h866);
        rst_n = 1'b0;
        cyc();
        checkOutput("rstInWait", status(0), 12'h000);
        rst_n = 1'b1;
        cyc();
        checkOutput("idleAfterRstWait", status(0), 12'h000);
        runTxn(0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 2, 0, "rdAfterRstWait");

        applyStimulus(0, 0, 1, 8'h40, 8'hC3);
        cyc();
        applyStimulus(0, 0, 0, 8'h40, 8'hC3);
        cyc();
        cyc();
        checkOutput("inAccess", status(0), 12'h800);
        rst_n = 1'b0;
        cyc();
        checkOutput("rstInAccess", status(0), 12'h000);
        rst_n = 1'b1;
        cyc();
        runTxn(0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 2, 0, "rdAfterRstAccess");

        runTxn(1, 1, 8'hFF, 8'h77, 8'h00, 8'h00, 0, 0, "wrB77");
        runTxn(1, 1, 8'h00, 8'h11, 8'h00, 8'h00, 0, 0, "wrB11");
        runTxn(1, 0, 8'hFF, 8'h00, 8'h00, 8'h77, 0, 0, "rdB77");
        runTxn(1, 0, 8'h00, 8'h00, 8'h77, 8'h11, 0, 0, "rdB11");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory access controller sitting directly upstream of the memory data register (MDR). It accepts read/write requests addressed by the MAR. It applies a programmable number of wait states, then accesses an internal single-port 8-bit data RAM. On reads it drives the fetched byte onto the MDR data input and pulses the MDR read-enable for exactly one cycle. On writes it stores the MDR output byte.

Parameters:
ADDR_W, 8, address width; RAM depth = 2**ADDR_W
DATA_W, 8, data width (matches MDR/C-bus width)
WAIT_STATES, 2, idle cycles inserted between request acceptance and the RAM access; legal range 0..15

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_rd  in  1  read request from control unit, sampled in IDLE only
req_wr  in  1  write request from control unit, sampled in IDLE only
addr  in  ADDR_W  address from MAR, latched on request acceptance
wr_data  in  DATA_W  write byte from MDR data_out, latched on request acceptance
rd_data  out  DATA_W  read byte to MDR data_in
mdr_read  out  1  one-cycle strobe to MDR read input; rd_data valid in the same cycle
busy  out  1  high from the cycle after acceptance until the cycle after completion
done  out  1  one-cycle completion pulse, for reads and writes
err  out  1  one-cycle pulse when req_rd and req_wr are both high in IDLE

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n. No asynchronous reset path.
- Reset values: rd_data=0, mdr_read=0, busy=0, done=0, err=0, state=IDLE, wait counter=0. RAM contents are not cleared by reset and are undefined at power-up.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE, exactly one of req_rd/req_wr high: latch addr, wr_data and op; load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACCESS.
- IDLE, both requests high: err=1 for one cycle, nothing latched, remain in IDLE.
- IDLE, neither request high: hold.
- WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1 (exactly WAIT_STATES cycles spent in WAIT).
- ACCESS: one cycle. Write: RAM[addr_q] <= wr_data_q. Read: RAM synchronous read issued. Go to RESP.
- RESP: one cycle. done=1. On a read, rd_data <= RAM output and mdr_read=1 in the same cycle. On a write, mdr_read stays 0 and rd_data holds. Go to IDLE.
- Latency from the accepting edge to the done pulse is WAIT_STATES+2 cycles. Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- busy=1 in WAIT, ACCESS and RESP, and 0 in IDLE.
- Requests arriving while busy are ignored and not queued; the control unit must re-issue them.
- addr/wr_data changes after acceptance have no effect (latched copies are used).
- rd_data holds its last read value until the next read completes.
- Reset asserted mid-operation: return to IDLE next edge with all outputs at reset values. A write not yet in ACCESS is aborted and the RAM is unchanged. A write in ACCESS on the reset edge is also suppressed (reset has priority).
- Address wraps naturally within ADDR_W bits; no out-of-range condition exists.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, WAIT, ACCESS, RESP), DATA_W/ADDR_W defaults, wait-counter width constant (4 bits).
- One sub-module: data_ram (single-port, synchronous write, registered read, parameterised ADDR_W/DATA_W, no reset on the array).
- Controller FSM, counter and output registers stay in data_mem_ctrl.

Test Plan:
- Reset, then write 0xA5 to addr 0x10 with WAIT_STATES=2 -> busy high for 4 cycles, done pulses 4 cycles after acceptance, mdr_read stays 0.
- Read addr 0x10 after that write -> rd_data=0xA5 with mdr_read=1 and done=1 in the same cycle, 4 cycles after acceptance; both are 0 on the next cycle.
- req_rd=1 and req_wr=1 together in IDLE -> err pulses once, busy stays 0, RAM unchanged (a later read of 0x10 returns 0xA5).
- Assert req_rd at addr 0x20 during busy, and change addr to 0x30 mid-operation -> second request ignored, access uses the latched address, only one done pulse.
- Write 0x3C to 0x40, pull rst_n low during WAIT -> all outputs 0 next cycle; a subsequent read of 0x40 does not return 0x3C (it returns the prior value, pre-written as 0x00).
- WAIT_STATES=0 instance: read 0xFF (pre-written 0x77) -> done and mdr_read 2 cycles after acceptance, rd_data=0x77; read 0x00 (pre-written 0x11) -> rd_data=0x11.
